alu_responder: RTL and testbench
================================

# alu_responder

Operation-execution end of the ALU start/done protocol: samples an operation request (`A`, `B`, `op_set`) on `start`, computes it with op-dependent latency and returns `result` with a one-cycle `done` pulse. It is the device the scoreboard-side monitor checks. Each `done` pulse must correspond to exactly one accepted add/and/xor/mul request, in order. Sits directly behind the testbench BFM signals in place of the ALU core.

## Interface
- `MUL_LATENCY`, default 3: cycles from the accepting edge to `done` for mul. Legal range is 2..8.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1  request valid; the requester holds it high until it sees `done`.
- `A`  in  8  operand A, unsigned.
- `B`  in  8  operand B, unsigned.
- `op_set`  in  3  opcode: no_op=000, add_op=001, and_op=010, xor_op=011, mul_op=100, rst_op=111; 101 and 110 are illegal.
- `done`  out  1  registered; high for exactly one cycle when `result` is valid.
- `result`  out  16  registered; holds the last computed value.

## Operation
- FSM states:
  - IDLE.
  - BUSY, with down-counter `cnt`.
  - DONE.
- IDLE with `start`=1 at edge N:
  - Capture `A`, `B` and `op_set` into internal registers. Later input changes have no effect on the current operation.
  - add/and/xor: compute at edge N; `result` and `done`=1 update at edge N+1. State goes IDLE → DONE.
  - mul: state goes to BUSY with `cnt` = `MUL_LATENCY`-1. The product A*B (full 16 bits, no truncation) is registered in at least 2 stages. `result` and `done` update at edge N+`MUL_LATENCY`, then state goes to DONE.
  - no_op, 101, 110: no capture, no `done`; `result` is unchanged and state stays IDLE.
  - rst_op: `result` is set to 0 at edge N+1, no `done`, state stays IDLE.
- Width rules:
  - add is a 9-bit sum, zero-extended to 16 bits.
  - and and xor are 8-bit, zero-extended to 16 bits.
- BUSY: `start`, `A`, `B` and `op_set` are ignored. `cnt` decrements each edge.
- DONE, which lasts one cycle: `done`=1. At the next edge `done` goes to 0 and state goes to IDLE. `start` is not sampled in DONE.
- Back-to-back requests: if `start` is still high in the first IDLE cycle after DONE, a new request is accepted. This allows a minimum spacing of 2 cycles between single-cycle requests.
- `result` keeps its value between operations. It changes only on completion, on rst_op, or on reset.

## Timing
- Reset: `reset_n`=0 at any edge forces:
  - state = IDLE, `done`=0, `result`=16'h0000;
  - the mul pipeline and `cnt` cleared; the internal operand registers cleared.
- Reset has priority over every other event, including completion in the same cycle.
- Reset during BUSY aborts the operation; no `done` is ever produced for it.
- The first request can be accepted at the first edge with `reset_n`=1.
- Latency, from the accepting edge to the rising of `done`:
  - 1 cycle for add/and/xor;
  - `MUL_LATENCY` cycles for mul.
- `done` is never high for two consecutive cycles. `done` and `result` change only at edges.
- There is at most one outstanding operation; no queueing.

## Test plan
- Reset, then add with A=255, B=255: `done` rises 1 cycle after acceptance, `result`=510. `done` drops the next cycle, and `result` still reads 510 afterwards.
- mul with A=255, B=255 and `MUL_LATENCY`=3: `done` rises exactly 3 cycles after acceptance, `result`=65025.
  - Changing A and B to 0 while BUSY has no effect on `result`.
- and A=8'hF0, B=8'h3C → `result`=16'h0030; xor with the same operands → `result`=16'h00CC. Each produces one `done` pulse.
- After a completed add giving 510:
  - no_op held for 10 cycles produces no `done` and `result` stays 510;
  - op_set=101 produces no `done`;
  - rst_op gives `result`=0 one cycle after acceptance, with no `done`.
- Start a mul, then assert `reset_n`=0 for one edge in the 2nd BUSY cycle: `done` never pulses and `result`=0. A following add 1+2 gives `result`=3 with a single `done` pulse.
- Hold `start`=1 with add 1+1 for 6 cycles: exactly 3 `done` pulses, 2 cycles apart, each with `result`=2.

Source files
------------

// File: rtl/alu_responder.sv
// Execution side of the ALU start/done protocol: accepts one add/and/xor/mul
// request at a time and answers each with a single-cycle done pulse.
module alu_responder #(
  parameter int MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op_set,
  output logic        done,
  output logic [15:0] result,
  output logic [1:0]  dbg_state
);

  // Handshake: start is valid and is held by the requester until it sees done.
  // A request is taken only in IDLE; done is high for exactly one cycle per
  // accepted add/and/xor/mul, and start is ignored while BUSY or DONE.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_RST = 3'b111;

  localparam logic [2:0] CNT_INIT = 3'(MUL_LATENCY - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] prod_q, prod_d;
  logic [15:0] result_q, result_d;
  logic        done_q, done_d;
  logic        clr_q, clr_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      op_q     <= 3'b000;
      prod_q   <= 16'h0000;
      result_q <= 16'h0000;
      done_q   <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      done_q   <= done_d;
      clr_q    <= clr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    prod_d   = prod_q;
    result_d = result_q;
    done_d   = 1'b0;
    clr_d    = 1'b0;

    // rst_op clears result one edge after it is taken
    if (clr_q) result_d = 16'h0000;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op_set)
            OP_ADD, OP_AND, OP_XOR: begin
              a_d     = A;
              b_d     = B;
              op_d    = op_set;
              state_d = S_DONE;
            end
            OP_MUL: begin
              a_d     = A;
              b_d     = B;
              op_d    = op_set;
              cnt_d   = CNT_INIT;
              state_d = S_BUSY;
            end
            OP_RST:  clr_d = 1'b1;
            default: ;
          endcase
        end
      end

      S_BUSY: begin
        // operand registers feed a product register; result takes the product
        prod_d = 16'(a_q) * 16'(b_q);
        if (cnt_q == 3'd0) begin
          result_d = prod_q;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      S_DONE: begin
        case (op_q)
          OP_ADD:  result_d = 16'(a_q) + 16'(b_q);
          OP_AND:  result_d = {8'h00, a_q & b_q};
          OP_XOR:  result_d = {8'h00, a_q ^ b_q};
          default: result_d = result_q;
        endcase
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_responder.sv
// Bench for alu_responder: scenario tasks plus a done-driven scoreboard that
// pops expected results in request order.
module tb_alu_responder;

  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  A = 8'h00;
  logic [7:0]  B = 8'h00;
  logic [2:0]  op_set = 3'b000;
  logic        done;
  logic [15:0] result;
  logic [1:0]  dbg_state;

  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  alu_responder #(.MUL_LATENCY(MUL_LAT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .A(A),
    .B(B),
    .op_set(op_set),
    .done(done),
    .result(result),
    .dbg_state(dbg_state)
  );

  // scoreboard: every done pulse pops one expected result
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (prev_done) begin
        compared++;
        mismatched++;
        $display("FAIL done_consecutive: done high two cycles in a row, required single pulse");
      end
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: result=%0d with no request outstanding", result);
      end else begin
        logic [15:0] exp_v;
        exp_v = exp_q.pop_front();
        compared++;
        if (result !== exp_v) begin
          mismatched++;
          $display("FAIL scoreboard_result: got %0d, expected %0d", result, exp_v);
        end
      end
    end
    prev_done = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int exp_lat, input logic [15:0] exp_val,
                        input bit scramble, input string name);
    int lat;
    bit seen;
    exp_q.push_back(exp_val);
    op_set = op;
    A = a;
    B = b;
    start = 1'b1;
    tick();
    compared++;
    if (dbg_state !== ((exp_lat == 1) ? 2'd2 : 2'd1)) begin
      mismatched++;
      $display("FAIL %s_state: got %0d after accept", name, dbg_state);
    end
    if (scramble) begin
      A = 8'h00;
      B = 8'h00;
    end
    lat = 0;
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      tick();
      lat = k;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    compared++;
    if (!seen || lat != exp_lat) begin
      mismatched++;
      $display("FAIL %s_latency: got %0d (seen=%0b), expected %0d", name, lat, seen, exp_lat);
    end
    tick();
    compared++;
    if (done !== 1'b0 || result !== exp_val) begin
      mismatched++;
      $display("FAIL %s_hold: done=%0b result=%0d, expected done=0 result=%0d",
               name, done, result, exp_val);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    compared++;
    if (done !== 1'b0 || result !== 16'h0000 || dbg_state !== 2'd0) begin
      mismatched++;
      $display("FAIL reset: done=%0b result=%0d state=%0d, expected 0/0/0", done, result, dbg_state);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_add();
    run_op(3'b001, 8'd255, 8'd255, 1, 16'd510, 1'b0, "add_max");
  endtask

  task automatic test_mul();
    run_op(3'b100, 8'd255, 8'd255, MUL_LAT, 16'd65025, 1'b1, "mul_max");
  endtask

  task automatic test_logic();
    run_op(3'b010, 8'hF0, 8'h3C, 1, 16'h0030, 1'b0, "and");
    run_op(3'b011, 8'hF0, 8'h3C, 1, 16'h00CC, 1'b0, "xor");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  op;
      logic [7:0]  a, b;
      logic [15:0] e;
      int          lat;
      op = 3'($urandom_range(1, 4));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      lat = 1;
      case (op)
        3'b001:  e = {7'd0, {1'b0, a} + {1'b0, b}};
        3'b010:  e = {8'd0, a & b};
        3'b011:  e = {8'd0, a ^ b};
        default: begin
          e = a * b;
          lat = MUL_LAT;
        end
      endcase
      run_op(op, a, b, lat, e, 1'b1, "random");
    end
  endtask

  task automatic test_ignored_ops();
    int dc;
    run_op(3'b001, 8'd255, 8'd255, 1, 16'd510, 1'b0, "add_pre");
    dc = done_cnt;
    op_set = 3'b000;
    start = 1'b1;
    repeat (10) tick();
    start = 1'b0;
    compared++;
    if (done_cnt != dc || result !== 16'd510) begin
      mismatched++;
      $display("FAIL no_op: dones=%0d result=%0d, expected 0 dones result=510", done_cnt - dc, result);
    end
    op_set = 3'b101;
    start = 1'b1;
    repeat (4) tick();
    start = 1'b0;
    tick();
    compared++;
    if (done_cnt != dc || result !== 16'd510) begin
      mismatched++;
      $display("FAIL illegal_op: dones=%0d result=%0d, expected 0 dones result=510", done_cnt - dc, result);
    end
    op_set = 3'b111;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    compared++;
    if (result !== 16'h0000) begin
      mismatched++;
      $display("FAIL rst_op_result: got %0d, expected 0", result);
    end
    repeat (3) tick();
    compared++;
    if (done_cnt != dc) begin
      mismatched++;
      $display("FAIL rst_op_done: got %0d dones, expected 0", done_cnt - dc);
    end
  endtask

  task automatic test_abort();
    int dc;
    run_op(3'b001, 8'd5, 8'd6, 1, 16'd11, 1'b0, "add_pre_abort");
    dc = done_cnt;
    op_set = 3'b100;
    A = 8'd255;
    B = 8'd255;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    compared++;
    if (result !== 16'h0000 || done !== 1'b0 || dbg_state !== 2'd0) begin
      mismatched++;
      $display("FAIL abort_reset: result=%0d done=%0b state=%0d, expected 0/0/0", result, done, dbg_state);
    end
    repeat (6) tick();
    compared++;
    if (done_cnt != dc) begin
      mismatched++;
      $display("FAIL abort_done: got %0d dones, expected 0", done_cnt - dc);
    end
    dc = done_cnt;
    run_op(3'b001, 8'd1, 8'd2, 1, 16'd3, 1'b0, "add_after_abort");
    compared++;
    if (done_cnt != dc + 1) begin
      mismatched++;
      $display("FAIL after_abort_pulses: got %0d, expected 1", done_cnt - dc);
    end
  endtask

  task automatic test_back_to_back();
    int dc;
    int npulse;
    int pos[$];
    dc = done_cnt;
    npulse = 0;
    repeat (3) exp_q.push_back(16'd2);
    op_set = 3'b001;
    A = 8'd1;
    B = 8'd1;
    start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (done) begin
        npulse++;
        pos.push_back(i);
      end
    end
    start = 1'b0;
    repeat (3) tick();
    compared++;
    if (npulse != 3 || done_cnt != dc + 3) begin
      mismatched++;
      $display("FAIL b2b_count: got %0d pulses (%0d total), expected 3", npulse, done_cnt - dc);
    end
    compared++;
    if (pos.size() != 3 || pos[0] != 2 || pos[1] != 4 || pos[2] != 6) begin
      mismatched++;
      $display("FAIL b2b_spacing: got %0d pulses at wrong cycles, expected cycles 2,4,6", pos.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_logic();
    test_ignored_ops();
    test_abort();
    test_back_to_back();
    test_random();
    repeat (3) tick();
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected results never produced, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
